alu_input_sequencer: RTL and testbench

Front-end loader for the ALU: turns the board's SWITCHES/BUTTONS entry protocol into registered operands A, B and OPCODE. Buttons are synchronized and edge-detected, and an enforced A→B→OP sequence is applied; it then issues a one-cycle VALID strobe to the ALU datapath. It sits between the board I/O pins and the ALU core inside the top level, and is the receiving end of the operator/testbench entry sequence.

---
 rtl/alu_input_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_input_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_sequencer.sv
// Operand/opcode entry front-end: synchronizes load buttons and enforces the A->B->OP order.
// Optional macro BUTTON_DEBOUNCE_EN adds a per-button stable-count debounce before edge detect.
module alu_input_sequencer #(
  parameter int SIZEDATA        = 8,
  parameter int SIZEOP          = 6,
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZEDATA-1:0]  switches,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [SIZEDATA-1:0]  data_a,
  output logic [SIZEDATA-1:0]  data_b,
  output logic [SIZEOP-1:0]    opcode,
  output logic                 valid,
  output logic                 err,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    WAIT_A   = 2'd0,
    WAIT_B   = 2'd1,
    WAIT_OP  = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t               cur, nxt;
  logic [N_BUTTONS-1:0] sync1, sync2, level, prev, rise, match;
  logic                 load_a, load_b, load_op, reject;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N_BUTTONS-1:0][CW-1:0] cnt;
  logic [N_BUTTONS-1:0]         db;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db  <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = db;
`else
  assign level = sync2;
`endif

  assign rise  = level & ~prev;
  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= WAIT_A;
    else       cur <= nxt;
  end

  // Accept only a single rising edge on the button owned by the current state.
  always_comb begin
    nxt     = cur;
    match   = '0;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    reject  = 1'b0;
    case (cur)
      WAIT_A:  match = N_BUTTONS'(1);
      WAIT_B:  match = N_BUTTONS'(2);
      WAIT_OP: match = N_BUTTONS'(4);
      default: match = '0;
    endcase
    if (cur == S_UNUSED) begin
      nxt = WAIT_A;
    end else if (rise == match) begin
      load_a  = (cur == WAIT_A);
      load_b  = (cur == WAIT_B);
      load_op = (cur == WAIT_OP);
      nxt     = (cur == WAIT_OP) ? WAIT_A : state_t'(cur + 2'd1);
    end else if (|rise) begin
      reject = 1'b1;
    end
  end

  // valid and err are single-cycle strobes with no back-pressure: valid rises in the
  // same cycle opcode updates and marks data_a/data_b/opcode as one complete operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      data_a <= '0;
      data_b <= '0;
      opcode <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      prev  <= level;
      valid <= load_op;
      err   <= reject;
      if (load_a)  data_a <= switches;
      if (load_b)  data_b <= switches;
      if (load_op) opcode <= switches[SIZEOP-1:0];
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: entry-order model, op scoreboard and
// directed literal checks (debounce pulse checks when BUTTON_DEBOUNCE_EN is defined).
module tb_alu_input_sequencer;
  localparam int W = 22;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switches;
  logic [2:0] buttons;
  logic [7:0] data_a, data_b;
  logic [5:0] opcode;
  logic       valid, err;
  logic [1:0] state;

  int tests_run = 0, tests_failed = 0;
  int valid_seen = 0, err_seen = 0;
  int v0, e0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;

  alu_input_sequencer dut (
    .clk(clk), .reset(reset), .switches(switches), .buttons(buttons),
    .data_a(data_a), .data_b(data_b), .opcode(opcode),
    .valid(valid), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a button sampled high at edge k acts at edge k+2; stage counts A,B,OP entries.
  logic [2:0] h1 = '0, h2 = '0, h3 = '0, m_rise;
  int         stage = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [5:0] m_op = '0;
  logic       m_valid = 1'b0, m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      stage = 0; m_a = '0; m_b = '0; m_op = '0;
      m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_rise  = h2 & ~h3;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (m_rise != 3'b000) begin
        if ($countones(m_rise) == 1 && m_rise == 3'(1 << stage)) begin
          if (stage == 0) m_a = switches;
          else if (stage == 1) m_b = switches;
          else begin
            m_op    = switches[5:0];
            m_valid = 1'b1;
            exp_q.push_back({m_a, m_b, m_op});
          end
          stage = (stage + 1) % 3;
        end else begin
          m_err = 1'b1;
        end
      end
      h3 = h2; h2 = h1; h1 = buttons;
    end
  end

  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (err) err_seen++;
  end

`ifndef BUTTON_DEBOUNCE_EN
  always @(negedge clk) begin
    chk("data_a", 32'(data_a), 32'(m_a));
    chk("data_b", 32'(data_b), 32'(m_b));
    chk("opcode", 32'(opcode), 32'(m_op));
    chk("valid",  32'(valid),  32'(m_valid));
    chk("err",    32'(err),    32'(m_err));
    chk("state",  32'(state),  32'(stage));
    if (valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_underflow: got op %0h with no expected op", {data_a, data_b, opcode});
      end else begin
        got = exp_q.pop_front();
        chk("sb_op", 32'({data_a, data_b, opcode}), 32'(got));
      end
    end
  end
`endif

  task automatic press(input logic [2:0] btn, input logic [7:0] sw, input int cyc);
    @(negedge clk);
    buttons  = btn;
    switches = sw;
    repeat (cyc) @(negedge clk);
    buttons = 3'b000;
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},     32'(data_a), 32'h0);
    chk({tag, "_b"},     32'(data_b), 32'h0);
    chk({tag, "_op"},    32'(opcode), 32'h0);
    chk({tag, "_valid"}, 32'(valid),  32'h0);
    chk({tag, "_err"},   32'(err),    32'h0);
    chk({tag, "_state"}, 32'(state),  32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    buttons  = 3'b000;
    switches = 8'h00;
    #13;
    chk_zero("reset_init");
    #9 reset = 1'b0;
    repeat (2) @(negedge clk);

`ifdef BUTTON_DEBOUNCE_EN
    press(3'b001, 8'h77, 3);
    repeat (4) @(negedge clk);
    #2;
    chk("db_short_state", 32'(state), 32'h0);
    chk("db_short_a",     32'(data_a), 32'h0);
    press(3'b001, 8'h66, 6);
    chk("db_long_a",     32'(data_a), 32'h66);
    chk("db_long_state", 32'(state),  32'h1);
`else
    // Normal A -> B -> OP sequence
    press(3'b001, 8'h24, 2);
    chk("seq_a", 32'(data_a), 32'h24);
    chk("seq_a_state", 32'(state), 32'h1);
    press(3'b010, 8'h81, 2);
    chk("seq_b", 32'(data_b), 32'h81);
    chk("seq_b_state", 32'(state), 32'h2);
    v0 = valid_seen;
    press(3'b100, 8'h20, 2);
    chk("seq_op", 32'(opcode), 32'h20);
    chk("seq_op_state", 32'(state), 32'h0);
    chk("seq_valid_once", 32'(valid_seen - v0), 32'h1);

    // Out of order B in WAIT_A
    e0 = err_seen;
    press(3'b010, 8'h55, 2);
    chk("ooo_err_once", 32'(err_seen - e0), 32'h1);
    chk("ooo_b_kept", 32'(data_b), 32'h81);
    chk("ooo_state", 32'(state), 32'h0);

    // Simultaneous A+B in WAIT_B, then a clean B
    press(3'b001, 8'h11, 2);
    e0 = err_seen;
    press(3'b011, 8'hAA, 2);
    chk("sim_err_once", 32'(err_seen - e0), 32'h1);
    chk("sim_state", 32'(state), 32'h1);
    chk("sim_a_kept", 32'(data_a), 32'h11);
    press(3'b010, 8'h09, 2);
    chk("sim_clean_b", 32'(data_b), 32'h09);
    chk("sim_clean_state", 32'(state), 32'h2);

    // Asynchronous reset mid-sequence, 20 ns wide
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_zero("reset_mid");
    #19 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_rel_state", 32'(state), 32'h0);

    // Held button: one capture, later switch changes ignored
    e0 = err_seen;
    @(negedge clk);
    buttons  = 3'b001;
    switches = 8'h0F;
    repeat (10) @(negedge clk);
    switches = 8'hF0;
    repeat (2) @(negedge clk);
    buttons = 3'b000;
    repeat (4) @(negedge clk);
    #2;
    chk("held_a", 32'(data_a), 32'h0F);
    chk("held_state", 32'(state), 32'h1);
    chk("held_no_err", 32'(err_seen - e0), 32'h0);

    // Button held through reset release is a fresh edge
    @(negedge clk);
    reset    = 1'b1;
    buttons  = 3'b001;
    switches = 8'h5A;
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    e0 = err_seen;
    repeat (5) @(negedge clk);
    buttons = 3'b000;
    repeat (3) @(negedge clk);
    #2;
    chk("thru_rst_a", 32'(data_a), 32'h5A);
    chk("thru_rst_b", 32'(data_b), 32'h00);
    chk("thru_rst_state", 32'(state), 32'h1);
    chk("thru_rst_no_err", 32'(err_seen - e0), 32'h0);

    // Finish op; upper switch bits must not reach the opcode
    press(3'b010, 8'h7E, 2);
    v0 = valid_seen;
    press(3'b100, 8'hC3, 2);
    chk("op_mask", 32'(opcode), 32'h03);
    chk("op_valid_once", 32'(valid_seen - v0), 32'h1);

    // Different buttons in consecutive cycles are handled one per cycle
    @(negedge clk);
    buttons  = 3'b001;
    switches = 8'h12;
    @(negedge clk);
    buttons = 3'b010;
    @(negedge clk);
    buttons = 3'b000;
    @(negedge clk);
    switches = 8'h34;
    repeat (4) @(negedge clk);
    #2;
    chk("consec_a", 32'(data_a), 32'h12);
    chk("consec_b", 32'(data_b), 32'h34);
    chk("consec_state", 32'(state), 32'h2);
    press(3'b100, 8'h05, 2);
    chk("consec_op", 32'(opcode), 32'h05);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
